// File: rtl/wb_regfile.sv
// Writeback stage with load extension, result select, a 31-entry register file
// with write-through bypass to the decode read ports, and cycle/retire counters.
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] PCPlus4W,
    input  logic [31:0] lAuiPCW,
    input  logic [31:0] InstrW,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcW,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    output logic [31:0] ResultW,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [63:0] CycleCnt,
    output logic [63:0] InstRetCnt
);

    logic [4:0]  rd_w;
    logic [2:0]  funct3_w;
    logic [1:0]  offset_w;
    logic        write_en;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] instret_cnt_q, instret_cnt_d;

    assign rd_w     = InstrW[11:7];
    assign funct3_w = InstrW[14:12];
    assign offset_w = ALUResultW[1:0];
    assign write_en = RegWriteW && (rd_w != 5'd0);

    always_comb begin
        byte_sel = ReadDataW[7:0];
        case (offset_w)
            2'd0: byte_sel = ReadDataW[7:0];
            2'd1: byte_sel = ReadDataW[15:8];
            2'd2: byte_sel = ReadDataW[23:16];
            2'd3: byte_sel = ReadDataW[31:24];
            default: byte_sel = ReadDataW[7:0];
        endcase
        // Halves are naturally aligned, so offset bit 0 plays no part.
        half_sel = offset_w[1] ? ReadDataW[31:16] : ReadDataW[15:0];
        load_ext = ReadDataW;
        case (funct3_w)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = ReadDataW;
        endcase
    end

    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = load_ext;
            2'b10:   ResultW = PCPlus4W;
            2'b11:   ResultW = lAuiPCW;
            default: ResultW = ALUResultW;
        endcase
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] value;
        if (addr == 5'd0)
            value = 32'd0;
        else if (RegWriteW && (rd_w == addr))
            value = ResultW;
        else
            value = regs_q[addr];
        return value;
    endfunction

    assign RD1D = read_port(A1D);
    assign RD2D = read_port(A2D);

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (write_en && (rd_w == 5'(i)))
                regs_d[i] = ResultW;
        end
        cycle_cnt_d   = cycle_cnt_q + 64'd1;
        instret_cnt_d = instret_cnt_q;
        if (InstrW != 32'd0)
            instret_cnt_d = instret_cnt_q + 64'd1;
    end

    // Reset wins over any same-edge register write or counter increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= 32'd0;
            cycle_cnt_q   <= 64'd0;
            instret_cnt_q <= 64'd0;
        end else begin
            regs_q        <= regs_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign CycleCnt   = cycle_cnt_q;
    assign InstRetCnt = instret_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, lAuiPCW, InstrW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  A1D, A2D;
    logic [31:0] ResultW, RD1D, RD2D;
    logic [63:0] CycleCnt, InstRetCnt;

    typedef enum int {SEL_RESULT, SEL_RD1, SEL_RD2, SEL_CYCLE, SEL_INSTRET} sel_t;

    typedef struct {
        sel_t        sel;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total_checks = 0;
    int   passed_checks = 0;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .lAuiPCW    (lAuiPCW),
        .InstrW     (InstrW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .A1D        (A1D),
        .A2D        (A2D),
        .ResultW    (ResultW),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .CycleCnt   (CycleCnt),
        .InstRetCnt (InstRetCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge and stay put for that whole cycle.
    task automatic applyStimulus(input logic rst, input logic rw, input logic [1:0] src,
                                 input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [31:0] instr, input logic [4:0] a1,
                                 input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset      = rst;
        RegWriteW  = rw;
        ResultSrcW = src;
        ALUResultW = alu;
        ReadDataW  = rdata;
        InstrW     = instr;
        A1D        = a1;
        A2D        = a2;
    endtask

    task automatic checkOutput(input sel_t sel, input logic [63:0] val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_RESULT:  act = {32'd0, ResultW};
                SEL_RD1:     act = {32'd0, RD1D};
                SEL_RD2:     act = {32'd0, RD2D};
                SEL_CYCLE:   act = CycleCnt;
                SEL_INSTRET: act = InstRetCnt;
                default:     act = 64'd0;
            endcase
            total_checks++;
            if (act === e.val)
                passed_checks++;
            else
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
        end
    end

    initial begin
        logic [9:0] pattern;
        reset      = 1'b1;
        RegWriteW  = 1'b0;
        ResultSrcW = 2'b00;
        ALUResultW = 32'd0;
        ReadDataW  = 32'd0;
        PCPlus4W   = 32'h0000_1004;
        lAuiPCW    = 32'h0040_2000;
        InstrW     = 32'd0;
        A1D        = 5'd0;
        A2D        = 5'd0;

        // Reset held with a write to x7: bypass still visible, write discarded.
        applyStimulus(1, 1, 2'b00, 32'hAAAA5555, 32'd0, 32'h000003B3, 5'd7, 5'd7);
        checkOutput(SEL_RESULT, 64'hAAAA5555, "reset_resultw");
        checkOutput(SEL_RD1, 64'hAAAA5555, "reset_bypass_rd1");
        checkOutput(SEL_RD2, 64'hAAAA5555, "reset_bypass_rd2");
        applyStimulus(0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd7, 5'd3);
        checkOutput(SEL_RD1, 64'd0, "reset_prio_x7");
        checkOutput(SEL_RD2, 64'd0, "reset_x3");
        checkOutput(SEL_CYCLE, 64'd0, "reset_cycle");
        checkOutput(SEL_INSTRET, 64'd0, "reset_instret");

        // Load extension and result select.
        applyStimulus(0, 0, 2'b01, 32'd2, 32'h80FF7F01, 32'h00000003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'hFFFFFFFF, "lb_off2");
        checkOutput(SEL_CYCLE, 64'd1, "cycle_after_first");
        checkOutput(SEL_INSTRET, 64'd0, "instret_bubble");
        applyStimulus(0, 0, 2'b01, 32'd3, 32'h80FF7F01, 32'h00000003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'hFFFFFF80, "lb_off3");
        applyStimulus(0, 0, 2'b01, 32'd1, 32'h80FF7F01, 32'h00000003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h0000007F, "lb_off1");
        applyStimulus(0, 0, 2'b01, 32'd0, 32'h80FF7F01, 32'h00000003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h00000001, "lb_off0");
        applyStimulus(0, 0, 2'b01, 32'd3, 32'h80FF7F01, 32'h00004003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h00000080, "lbu_off3");
        applyStimulus(0, 0, 2'b01, 32'd2, 32'h8001F00F, 32'h00001003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'hFFFF8001, "lh_off2");
        applyStimulus(0, 0, 2'b01, 32'd3, 32'h8001F00F, 32'h00001003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'hFFFF8001, "lh_off3");
        applyStimulus(0, 0, 2'b01, 32'd2, 32'h8001F00F, 32'h00005003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h00008001, "lhu_off2");
        applyStimulus(0, 0, 2'b01, 32'd0, 32'h8001F00F, 32'h00001003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'hFFFFF00F, "lh_off0");
        applyStimulus(0, 0, 2'b01, 32'd0, 32'h8001F00F, 32'h00005003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h0000F00F, "lhu_off0");
        applyStimulus(0, 0, 2'b01, 32'd2, 32'h8001F00F, 32'h00002003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h8001F00F, "lw");
        applyStimulus(0, 0, 2'b01, 32'd1, 32'h8001F00F, 32'h00007003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h8001F00F, "funct3_other");
        applyStimulus(0, 0, 2'b00, 32'h0BADF00D, 32'h8001F00F, 32'h00001003, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h0BADF00D, "sel_alu");
        applyStimulus(0, 0, 2'b10, 32'h0BADF00D, 32'h8001F00F, 32'h00000013, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h00001004, "sel_pcplus4");
        applyStimulus(0, 0, 2'b11, 32'h0BADF00D, 32'h8001F00F, 32'h00000013, 5'd0, 5'd0);
        checkOutput(SEL_RESULT, 64'h00402000, "sel_auipc");

        // Write x5 with same-cycle bypass on both ports, then read it stored.
        applyStimulus(0, 1, 2'b00, 32'h12345678, 32'd0, 32'h00000293, 5'd5, 5'd5);
        checkOutput(SEL_RD1, 64'h12345678, "bypass_rd1_x5");
        checkOutput(SEL_RD2, 64'h12345678, "bypass_rd2_x5");
        applyStimulus(0, 0, 2'b00, 32'h0, 32'd0, 32'd0, 5'd5, 5'd5);
        checkOutput(SEL_RD1, 64'h12345678, "stored_rd1_x5");
        checkOutput(SEL_RD2, 64'h12345678, "stored_rd2_x5");

        // Write to rd=0 is ignored and never bypassed.
        applyStimulus(0, 1, 2'b00, 32'hDEADBEEF, 32'd0, 32'h00000013, 5'd0, 5'd5);
        checkOutput(SEL_RD1, 64'd0, "x0_no_bypass");
        checkOutput(SEL_RD2, 64'h12345678, "x5_unchanged");
        applyStimulus(0, 0, 2'b00, 32'h0, 32'd0, 32'd0, 5'd0, 5'd6);
        checkOutput(SEL_RD1, 64'd0, "x0_after_write");
        checkOutput(SEL_RD2, 64'd0, "x6_untouched");

        // Counter run: reset, then 10 cycles with 6 retiring instructions.
        applyStimulus(1, 0, 2'b00, 32'h0, 32'd0, 32'h00000013, 5'd5, 5'd0);
        pattern = 10'b01_0110_1011;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 2'b00, 32'h0, 32'd0,
                          pattern[i] ? 32'h00000013 : 32'd0, 5'd5, 5'd0);
            if (i == 0) begin
                checkOutput(SEL_CYCLE, 64'd0, "cycle_first_after_reset");
                checkOutput(SEL_RD1, 64'd0, "x5_cleared_by_reset");
            end
        end
        applyStimulus(0, 0, 2'b00, 32'h0, 32'd0, 32'd0, 5'd5, 5'd0);
        checkOutput(SEL_CYCLE, 64'd10, "cycle_after_10");
        checkOutput(SEL_INSTRET, 64'd6, "instret_after_10");

        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            total_checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ALUResultW, ReadDataW, PCPlus4W, lAuiPCW, InstrW  input  32 each  writeback-stage values from the memory/writeback pipeline register.
REQ-005 RegWriteW  input  1  register write enable for the writeback instruction.
REQ-006 ResultSrcW  input  2  result select: 00 ALUResultW, 01 extended load data, 10 PCPlus4W, 11 lAuiPCW.
REQ-007 A1D, A2D  input  5 each  decode-stage source register addresses.
REQ-008 ResultW  output  32  final writeback value (combinational).
REQ-009 RD1D, RD2D  output  32 each  decode-stage read data (combinational).
REQ-010 CycleCnt, InstRetCnt  output  64 each  free-running cycle and retired-instruction counters.

Function
REQ-011 rdW SHALL be InstrW[11:7]; funct3W SHALL be InstrW[14:12]; byte offset SHALL be ALUResultW[1:0].
REQ-012 Load extension, applied only when ResultSrcW=01: funct3W 000 LB, sign-extended byte at offset; 001 LH, sign-extended half at offset[1]; 010 LW, full word; 100 LBU, zero-extended byte; 101 LHU, zero-extended half; any other funct3W SHALL pass the full word.
REQ-013 Half-word select: offset[1]=0 SHALL use bits [15:0]; offset[1]=1 SHALL use bits [31:16]; offset[0] SHALL be ignored for halves.
REQ-014 Byte select: offset 0..3 SHALL use bits [7:0], [15:8], [23:16], [31:24] respectively.
REQ-015 ResultW SHALL be selected by ResultSrcW per REQ-006, with no latency.
REQ-016 The register file SHALL hold 31 32-bit registers x1..x31; x0 SHALL always read 0 and SHALL never be written.
REQ-017 On a rising clk edge with reset=0, RegWriteW=1 and rdW!=0, register rdW SHALL be loaded with ResultW.
REQ-018 Read ports SHALL be combinational: RDnD = 0 if AnD=0; otherwise ResultW if RegWriteW=1 and rdW=AnD (write-through bypass); otherwise the stored register.
REQ-019 Both read ports SHALL be able to address the same register, or the register being written, in the same cycle, with identical results.
REQ-020 CycleCnt SHALL increment by 1 every clock with reset=0, wrapping from 2^64-1 to 0.
REQ-021 InstRetCnt SHALL increment by 1 on every clock with reset=0 and InstrW!=0; a bubble (InstrW=0) SHALL NOT count.
REQ-022 InstRetCnt SHALL wrap from 2^64-1 to 0.
REQ-023 Counters SHALL NOT affect, and SHALL NOT be affected by, register file contents.

Reset
REQ-024 With reset=1 at a rising edge, all of x1..x31 SHALL become 0, CycleCnt SHALL become 0 and InstRetCnt SHALL become 0.
REQ-025 Reset SHALL take priority over a simultaneous register write and over counter increments.
REQ-026 In the first cycle after reset deasserts, CycleCnt SHALL read 0, then increment at the next edge.
REQ-027 ResultW and RD1D/RD2D SHALL remain combinational during reset; RDnD SHALL reflect bypass per REQ-018 and stored value 0.

Verification
REQ-028 LB sign extension: ReadDataW=0x80FF7F01, ALUResultW[1:0]=2, funct3=000, ResultSrcW=01 -> ResultW=0xFFFFFFFF; offset 3 -> 0xFFFFFF80; LBU at offset 3 -> 0x00000080.
REQ-029 LH/LHU: ReadDataW=0x8001F00F, offset 2, LH -> 0xFFFF8001; LHU -> 0x00008001; LH at offset 0 -> 0xFFFFF00F.
REQ-030 Write then bypass: RegWriteW=1, InstrW rd=5, ResultSrcW=00, ALUResultW=0x12345678, A1D=A2D=5 -> RD1D=RD2D=0x12345678 in the same cycle, and still 0x12345678 after the edge with RegWriteW=0.
REQ-031 x0 protection: RegWriteW=1, rd=0, ALUResultW=0xDEADBEEF -> after the edge, A1D=0 reads 0; bypass SHALL NOT apply.
REQ-032 Reset priority: reset=1 together with a write of 0xAAAA5555 to x7 -> after the edge, x7=0, CycleCnt=0, InstRetCnt=0.
REQ-033 Counters: 10 cycles after reset, with InstrW nonzero in 6 of them and 0 in 4 -> CycleCnt=10, InstRetCnt=6.
